pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
// - Central stall/flush/halt sequencer for the 5-stage core: pc, if_id, id_ex, ex_mem, mem_wb.
// - Merges stage stall requests and the EX branch-redirect request into one stall vector,
//   one flush strobe and one redirect PC.
// - Also drains the pipeline and parks it on an external halt request; resumes on command.
// PARAMETERS
// - FLUSH_CYCLES  1   cycles flush stays high per redirect (covers ROM latency); >=1
// - DRAIN_CYCLES  3   bubble cycles injected before HALTED; >=1
// - ADDR_W        32  redirect address width; equals InstAddrBus width
// - CNT_W         32  perf counter width (PIPE_PERF_EN only)
// PORTS
// - clk              in   1       core clock
// - rst              in   1       synchronous, active-high reset
// - stallreq_id      in   1       ID load-use hazard; stall one cycle per assertion
// - stallreq_ex      in   1       EX multicycle op busy; level, held while busy
// - flushreq         in   1       EX branch/jump taken; 1-cycle pulse
// - flushaddr        in   ADDR_W  redirect target, valid with flushreq
// - halt_req         in   1       external halt; level
// - halt_resume      in   1       leave HALTED; 1-cycle pulse
// - stall            out  6       hold enables: [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]wb
// - flush            out  1       squash IF/ID and ID/EX contents; load pc from newpc
// - newpc            out  ADDR_W  redirect PC
// - halted           out  1       pipeline parked and empty
// - stall_cnt        out  CNT_W   stall cycles since reset (PIPE_PERF_EN only)
// - flush_cnt        out  CNT_W   redirects since reset (PIPE_PERF_EN only)
// BEHAVIOUR
// - Reset (rst=1 at posedge): state=RUN, counters=0, newpc_q=0.
//   - While rst=1, all outputs are forced 0 combinationally.
// - States: RUN, FLUSH, DRAIN, HALTED. 2-bit state reg plus one down-counter cnt_q.
// - stall, flush and newpc are combinational from state and inputs: zero-cycle latency.
// - A stage with stall[i]=1 and stall[i+1]=0 injects a bubble into stage i+1.
// - RUN, priority flushreq > stallreq_ex > stallreq_id:
//   - flushreq: flush=1, newpc=flushaddr, stall=0.
//     - FLUSH_CYCLES>1: go FLUSH, cnt=FLUSH_CYCLES-1, latch newpc_q=flushaddr.
//     - FLUSH_CYCLES=1: stay RUN.
//   - else stallreq_ex: stall=6'b001111.
//   - else stallreq_id: stall=6'b000111.
//   - else stall=0.
//   - halt_req with no flushreq: go DRAIN, cnt=DRAIN_CYCLES-1. stall requests still apply this cycle.
// - FLUSH:
//   - flush=1, newpc=newpc_q, stall=0. flushreq and stall requests ignored (pipe squashed).
//   - Decrement cnt; at cnt=0 go RUN (or DRAIN if halt_req=1).
// - DRAIN:
//   - Base stall=6'b000011: pc and if_id frozen, bubbles fed into id_ex.
//   - stallreq_ex: stall=6'b001111 and cnt frozen.
//   - flushreq: flush=1, newpc=flushaddr, latch newpc_q, reload cnt=DRAIN_CYCLES-1.
//     pc loads newpc despite stall[0]=1.
//   - cnt=0 with no stallreq_ex/flushreq: go HALTED.
//   - halt_req deasserted mid-drain: go RUN next cycle, pipeline resumes intact.
// - HALTED:
//   - stall=6'b111111, halted=1. All requests ignored.
//   - halt_resume: go RUN next cycle. halt_resume with halt_req still 1 does the same;
//     halt re-entry then needs halt_req to fall, then rise again (edge-armed flag).
// - Simultaneous flushreq + halt_req in RUN: flush is served first, halt entered on the
//   following cycle if still requested.
// - Mid-operation rst: state, counters and outputs return to reset values at that clock edge.
// CONFIGURATION
// - Macro PIPE_PERF_EN.
// - Defined:
//   - stall_cnt += 1 each cycle with stall!=0, excluding HALTED.
//   - flush_cnt += 1 per accepted redirect, i.e. per cycle flushreq is honoured.
//   - Both wrap modulo 2^CNT_W and clear on rst.
// - Undefined: stall_cnt and flush_cnt ports are absent; no counter logic.
// TESTING
// - Reset: rst=1 for 2 cycles -> stall=0, flush=0, newpc=0, halted=0. Then idle RUN, stall=0.
// - Priority: stallreq_id=1, then stallreq_ex=1 the same cycle -> stall=6'b001111.
//   Add flushreq, flushaddr=32'h40 -> stall=0, flush=1, newpc=32'h40.
// - FLUSH_CYCLES=3, flushreq pulse at 32'h100 -> flush high exactly 3 cycles, newpc=32'h100 throughout.
//   Second flushreq in cycle 2 is ignored.
// - halt_req=1 from RUN, DRAIN_CYCLES=3 -> stall=6'b000011 for 3 cycles, then halted=1, stall=6'b111111.
//   halt_resume pulse -> next cycle stall=0, halted=0.
// - Drain interrupt: stallreq_ex=1 for 4 cycles during DRAIN -> cnt frozen, HALTED 4 cycles later than nominal.
//   flushreq during DRAIN -> drain restarts at 3.
// - PIPE_PERF_EN: 5 stall cycles + 2 redirects -> stall_cnt=5, flush_cnt=2. CNT_W=4 wrap: 17 stall cycles -> stall_cnt=1.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall / flush / halt sequencer for the 5-stage core
// (pc, if_id, id_ex, ex_mem, mem_wb, wb hold enables).
// Optional feature macro: PIPE_PERF_EN adds stall_cnt / flush_cnt perf counters.
// stall, flush, newpc and halted are combinational from state and inputs so a
// request takes effect in the same cycle it is raised.

module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              flushreq,
  input  logic [ADDR_W-1:0] flushaddr,
  input  logic              halt_req,
  input  logic              halt_resume,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [ADDR_W-1:0] newpc,
  output logic              halted
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // Down-counter sized for the longer of the two sequences.
  localparam int unsigned CNT_MAX = (FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES;
  localparam int unsigned DCNT_W  = $clog2(CNT_MAX + 1);

  localparam logic [DCNT_W-1:0] FLUSH_LOAD = DCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);
  localparam logic [DCNT_W-1:0] CNT_ONE    = DCNT_W'(1);
  localparam logic [DCNT_W-1:0] CNT_ZERO   = DCNT_W'(0);

  // A single-cycle flush never needs the FLUSH state.
  localparam bit FLUSH_MULTI = (FLUSH_CYCLES > 1);

  // Hold-enable patterns: bit0 pc ... bit5 wb.
  localparam logic [5:0] STALL_NONE  = 6'b000000;
  localparam logic [5:0] STALL_ID    = 6'b000111;
  localparam logic [5:0] STALL_EX    = 6'b001111;
  localparam logic [5:0] STALL_DRAIN = 6'b000011;
  localparam logic [5:0] STALL_ALL   = 6'b111111;

  // Reject parameter values the sequencing cannot honour.
  if (FLUSH_CYCLES < 1 || DRAIN_CYCLES < 1 || CNT_W < 1 || ADDR_W < 1) begin : g_bad_param
    $error("pipe_ctrl: invalid parameter value");
  end

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_FLUSH  = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DCNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   newpc_q, newpc_d;
  logic                armed_q, armed_d;
  logic                accept_flush;
  logic                halt_go;

  // A redirect is honoured only where the pipe is not already squashed or parked.
  assign accept_flush = !rst && flushreq && (state_q == S_RUN || state_q == S_DRAIN);

  // Halt entry is edge-armed: after a resume with halt_req still high, it must drop first.
  assign halt_go = halt_req && armed_q;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= CNT_ZERO;
      newpc_q <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      newpc_q <= newpc_d;
      armed_q <= armed_d;
    end
  end

  // Next-state, counter, redirect latch and halt-arm logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    newpc_d = newpc_q;
    armed_d = armed_q;

    if (!halt_req) begin
      armed_d = 1'b1;
    end else if (state_q == S_HALTED && halt_resume) begin
      armed_d = 1'b0;
    end

    if (accept_flush) begin
      newpc_d = flushaddr;
    end

    case (state_q)
      S_RUN: begin
        if (flushreq) begin
          // Flush wins; a pending halt is picked up once the flush is over.
          if (FLUSH_MULTI) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_LOAD;
          end
        end else if (halt_go) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end

      S_FLUSH: begin
        // cnt_q counts the FLUSH cycles still to spend, this one included.
        if (cnt_q == CNT_ONE) begin
          if (halt_go) begin
            state_d = S_DRAIN;
            cnt_d   = DRAIN_LOAD;
          end else begin
            state_d = S_RUN;
            cnt_d   = CNT_ZERO;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_DRAIN: begin
        if (flushreq) begin
          // Redirected instructions re-enter the pipe, so the drain restarts.
          if (halt_req) begin
            cnt_d = DRAIN_LOAD;
          end else if (FLUSH_MULTI) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_LOAD;
          end else begin
            state_d = S_RUN;
            cnt_d   = CNT_ZERO;
          end
        end else if (!halt_req) begin
          state_d = S_RUN;
          cnt_d   = CNT_ZERO;
        end else if (stallreq_ex) begin
          cnt_d = cnt_q;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = S_HALTED;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_HALTED: begin
        if (halt_resume) begin
          state_d = S_RUN;
          cnt_d   = CNT_ZERO;
        end
      end

      default: begin
        state_d = S_RUN;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Combinational stall / flush / newpc / halted, all forced low under reset.
  always_comb begin
    stall  = STALL_NONE;
    flush  = 1'b0;
    newpc  = newpc_q;
    halted = 1'b0;

    if (rst) begin
      newpc = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (flushreq) begin
            flush = 1'b1;
            newpc = flushaddr;
          end else if (stallreq_ex) begin
            stall = STALL_EX;
          end else if (stallreq_id) begin
            stall = STALL_ID;
          end
        end

        S_FLUSH: begin
          flush = 1'b1;
        end

        S_DRAIN: begin
          // pc still loads newpc on a redirect even though stall[0] is set.
          stall = stallreq_ex ? STALL_EX : STALL_DRAIN;
          if (flushreq) begin
            flush = 1'b1;
            newpc = flushaddr;
          end
        end

        S_HALTED: begin
          stall  = STALL_ALL;
          halted = 1'b1;
        end

        default: begin
          stall = STALL_NONE;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Perf counters: stalled non-halted cycles and honoured redirects, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall != STALL_NONE && state_q != S_HALTED) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (accept_flush) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter outputs read zero while reset is held.
  always_comb begin
    stall_cnt = rst ? '0 : stall_cnt_q;
    flush_cnt = rst ? '0 : flush_cnt_q;
  end
`endif

endmodule
